// File: rtl/dsp_mac_sequencer_pkg.sv
// dsp_mac_seq_pkg: shared types and constants for the DSP48A1 MAC sequencer.
//   state_t      - sequencer FSM states
//   OPM_*        - OPMODE encodings for the slice (X = M, Z = 0 or P)
//   PIPE_LAT     - cycles from the last operand accept to a valid result
//   make_opmode  - builds the OPMODE word for one element
package dsp_mac_seq_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RESULT} state_t;

  localparam logic [7:0] OPM_FIRST   = 8'h01;  // X = M, Z = 0
  localparam logic [7:0] OPM_ACC     = 8'h09;  // X = M, Z = P
  localparam int         OPM_SUB_BIT = 7;      // post-adder subtract
  localparam int         PIPE_LAT    = 3;

  // Pre-adder and carry-in bits stay 0; only the subtract bit varies.
  function automatic logic [7:0] make_opmode(input logic first, input logic sub);
    logic [7:0] opm;
    opm = first ? OPM_FIRST : OPM_ACC;
    opm[OPM_SUB_BIT] = sub;
    return opm;
  endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// dsp_mac_sequencer_if: fabric-side handshakes of the MAC sequencer.
//   cmd_*  - dot-product command (length, subtract mode)
//   s_*    - operand pair stream
//   r_*    - accumulated result
// Modports: slave = sequencer, master = fabric driving it.
interface dsp_mac_sequencer_if #(
  parameter int WIDTH_2 = 18,
  parameter int WIDTH_4 = 48,
  parameter int LEN_W   = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [LEN_W-1:0]   cmd_len;
  logic               cmd_sub;
  logic               s_valid;
  logic               s_ready;
  logic [WIDTH_2-1:0] s_a;
  logic [WIDTH_2-1:0] s_b;
  logic               r_valid;
  logic               r_ready;
  logic [WIDTH_4-1:0] r_data;
  logic               r_carry;

  modport slave (
    input  cmd_valid, cmd_len, cmd_sub, s_valid, s_a, s_b, r_ready,
    output cmd_ready, s_ready, r_valid, r_data, r_carry
  );

  modport master (
    output cmd_valid, cmd_len, cmd_sub, s_valid, s_a, s_b, r_ready,
    input  cmd_ready, s_ready, r_valid, r_data, r_carry
  );
endinterface

// File: rtl/dsp_mac_sequencer_ce_pipe.sv
// dsp_ce_pipe: two-stage shift of {accept, first, sub} that times the slice
// enables behind each operand accept.
//   accept/first/sub  in  - accept strobe, first-element flag, subtract mode
//   ce_opmode, ce_m   out - one cycle after the accept (M and OPMODE regs)
//   ce_p, ce_carryin  out - two cycles after the accept (P and CARRYOUT regs)
//   opmode            out - OPMODE word aligned with ce_opmode, else 0
import dsp_mac_seq_pkg::*;

module dsp_ce_pipe (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       accept,
  input  logic       first,
  input  logic       sub,
  output logic       ce_opmode,
  output logic       ce_m,
  output logic       ce_p,
  output logic       ce_carryin,
  output logic [7:0] opmode
);
  logic acc1_reg, first1_reg, sub1_reg, acc2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc1_reg   <= 1'b0;
      first1_reg <= 1'b0;
      sub1_reg   <= 1'b0;
      acc2_reg   <= 1'b0;
    end else begin
      acc1_reg   <= accept;
      first1_reg <= first;
      sub1_reg   <= sub;
      acc2_reg   <= acc1_reg;
    end
  end

  // A stream bubble leaves a 0 in the shift, so every stage simply holds.
  assign ce_opmode  = acc1_reg;
  assign ce_m       = acc1_reg;
  assign ce_p       = acc2_reg;
  assign ce_carryin = acc2_reg;
  assign opmode     = acc1_reg ? make_opmode(first1_reg, sub1_reg) : 8'h00;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: command-driven initiator for one DSP48A1 slice computing
// (+/-) sum(A*B) over a stream of operand pairs.
//   clk, rst_n          - clock, asynchronous active-low reset
//   bus (slave)         - command, operand stream and result handshakes
//   dsp_a, dsp_b        - slice A/B, passed straight from the stream
//   dsp_opmode, dsp_ce* - slice OPMODE and clock enables
//   dsp_p, dsp_carryout - slice P/CARRYOUT read back as the result
// Slice setup assumed: A1/B1/OPMODE/M/P/CARRYOUT registers on, A0/B0 off,
// direct B input, carry-in from OPMODE[5], C/D/PCIN tied to 0.
import dsp_mac_seq_pkg::*;

module dsp_mac_sequencer #(
  parameter int WIDTH_2 = 18,
  parameter int WIDTH_4 = 48,
  parameter int LEN_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  dsp_mac_sequencer_if.slave bus,
  output logic [WIDTH_2-1:0] dsp_a,
  output logic [WIDTH_2-1:0] dsp_b,
  output logic [7:0]         dsp_opmode,
  output logic               dsp_cea,
  output logic               dsp_ceb,
  output logic               dsp_ceopmode,
  output logic               dsp_cem,
  output logic               dsp_cep,
  output logic               dsp_cecarryin,
  input  logic [WIDTH_4-1:0] dsp_p,
  input  logic               dsp_carryout
);
  // DRAIN covers the two cycles between the last accept and P capture.
  localparam logic [1:0] DRAIN_LAST = 2'(PIPE_LAT - 2);

  state_t           state_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] cnt_reg;
  logic [1:0]       drain_reg;
  logic             sub_reg;
  logic             zero_reg;
  logic             cmd_ready_reg;
  logic             s_ready_reg;
  logic             r_valid_reg;
  logic             accept;

  assign accept = s_ready_reg && bus.s_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      cnt_reg       <= '0;
      drain_reg     <= '0;
      sub_reg       <= 1'b0;
      zero_reg      <= 1'b0;
      cmd_ready_reg <= 1'b1;
      s_ready_reg   <= 1'b0;
      r_valid_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.cmd_valid) begin
            len_reg       <= bus.cmd_len;
            sub_reg       <= bus.cmd_sub;
            cnt_reg       <= '0;
            cmd_ready_reg <= 1'b0;
            if (bus.cmd_len == '0) begin
              zero_reg    <= 1'b1;
              r_valid_reg <= 1'b1;
              state_reg   <= RESULT;
            end else begin
              zero_reg    <= 1'b0;
              s_ready_reg <= 1'b1;
              state_reg   <= STREAM;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            cnt_reg <= cnt_reg + LEN_W'(1);
            if (cnt_reg == len_reg - LEN_W'(1)) begin
              s_ready_reg <= 1'b0;
              drain_reg   <= '0;
              state_reg   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_reg == DRAIN_LAST) begin
            r_valid_reg <= 1'b1;
            state_reg   <= RESULT;
          end else begin
            drain_reg <= drain_reg + 2'd1;
          end
        end
        RESULT: begin
          if (bus.r_ready) begin
            r_valid_reg   <= 1'b0;
            cmd_ready_reg <= 1'b1;
            zero_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_reg;
  assign bus.s_ready   = s_ready_reg;
  assign bus.r_valid   = r_valid_reg;
  // Gated by r_valid so the result port reads 0 outside RESULT.
  assign bus.r_data    = (r_valid_reg && !zero_reg) ? dsp_p : '0;
  assign bus.r_carry   = r_valid_reg && !zero_reg && dsp_carryout;

  assign dsp_a   = s_ready_reg ? bus.s_a : '0;
  assign dsp_b   = s_ready_reg ? bus.s_b : '0;
  assign dsp_cea = accept;
  assign dsp_ceb = accept;

  dsp_ce_pipe u_ce_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept     (accept),
    .first      (cnt_reg == '0),
    .sub        (sub_reg),
    .ce_opmode  (dsp_ceopmode),
    .ce_m       (dsp_cem),
    .ce_p       (dsp_cep),
    .ce_carryin (dsp_cecarryin),
    .opmode     (dsp_opmode)
  );

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Testbench for dsp_mac_sequencer: a behavioural DSP48A1 slice sits behind the
// DUT; expected results are computed from the operands with plain arithmetic
// and queued at command issue, and a monitor pops them on each result handshake.
module tb_dsp_mac_sequencer;
  localparam int W2 = 18;
  localparam int W4 = 48;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dsp_mac_sequencer_if #(.WIDTH_2(W2), .WIDTH_4(W4), .LEN_W(LW)) bus ();

  logic [W2-1:0] dsp_a, dsp_b;
  logic [7:0]    dsp_opmode;
  logic          dsp_cea, dsp_ceb, dsp_ceopmode, dsp_cem, dsp_cep, dsp_cecarryin;
  logic [W4-1:0] dsp_p;
  logic          dsp_carryout;

  dsp_mac_sequencer #(.WIDTH_2(W2), .WIDTH_4(W4), .LEN_W(LW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .dsp_a         (dsp_a),
    .dsp_b         (dsp_b),
    .dsp_opmode    (dsp_opmode),
    .dsp_cea       (dsp_cea),
    .dsp_ceb       (dsp_ceb),
    .dsp_ceopmode  (dsp_ceopmode),
    .dsp_cem       (dsp_cem),
    .dsp_cep       (dsp_cep),
    .dsp_cecarryin (dsp_cecarryin),
    .dsp_p         (dsp_p),
    .dsp_carryout  (dsp_carryout)
  );

  // ---------------- behavioural DSP48A1 slice (not reset by rst_n) ----------
  logic [W2-1:0] a1_m = '0, b1_m = '0;
  logic [35:0]   m_m = '0;
  logic [7:0]    opm_m = '0;
  logic [W4-1:0] p_m = '0;
  logic          co_m = 1'b0;
  logic [W4:0]   alu;

  always_comb begin : slice_alu
    logic [W4-1:0] z, x;
    z = (opm_m[3:2] == 2'b10) ? p_m : '0;
    x = (opm_m[1:0] == 2'b01) ? {12'd0, m_m} : '0;
    alu = opm_m[7] ? ({1'b0, z} - {1'b0, x}) : ({1'b0, z} + {1'b0, x});
  end

  always @(posedge clk) begin
    if (dsp_cea)       a1_m  <= dsp_a;
    if (dsp_ceb)       b1_m  <= dsp_b;
    if (dsp_cem)       m_m   <= a1_m * b1_m;
    if (dsp_ceopmode)  opm_m <= dsp_opmode;
    if (dsp_cep)       p_m   <= alu[W4-1:0];
    if (dsp_cecarryin) co_m  <= alu[W4];
  end
  assign dsp_p        = p_m;
  assign dsp_carryout = co_m;

  // ---------------- bookkeeping ---------------------------------------------
  typedef struct {
    logic [W4-1:0] data;
    bit            chk_carry;
  } exp_t;

  exp_t          sb_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  longint        cyc = 0;
  bit            hold_mode = 1'b0;
  bit            rand_rdy = 1'b0;
  logic [W2-1:0] a_arr[16];
  logic [W2-1:0] b_arr[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no event, expected one within bound (cycle %0d)", name, cyc);
  endtask

  // ---------------- result ready driver --------------------------------------
  initial begin
    bus.r_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_mode)     bus.r_ready = 1'b0;
      else if (rand_rdy) bus.r_ready = 1'($urandom_range(0, 1));
      else               bus.r_ready = 1'b1;
    end
  end

  // ---------------- monitor: enables, OPMODE, latency, scoreboard ------------
  bit          acc_d1 = 1'b0, acc_d2 = 1'b0, prev_rv = 1'b0, cur_sub = 1'b0;
  logic [7:0]  opm_d1 = '0;
  int          elem = 0;
  int          exp_lat = 3;
  longint      last_ev = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      acc_d1  = 1'b0;
      acc_d2  = 1'b0;
      prev_rv = 1'b0;
    end else begin : mon
      bit         acc;
      logic [7:0] opm_now;
      exp_t       e;
      acc = bus.s_valid && bus.s_ready;
      chk("dsp_cea", 64'(dsp_cea), 64'(acc));
      chk("dsp_ceb", 64'(dsp_ceb), 64'(acc));
      chk("dsp_ceopmode", 64'(dsp_ceopmode), 64'(acc_d1));
      chk("dsp_cem", 64'(dsp_cem), 64'(acc_d1));
      chk("dsp_cep", 64'(dsp_cep), 64'(acc_d2));
      chk("dsp_cecarryin", 64'(dsp_cecarryin), 64'(acc_d2));
      if (acc_d1) chk("dsp_opmode", 64'(dsp_opmode), 64'(opm_d1));
      if (acc) begin
        chk("dsp_a", 64'(dsp_a), 64'(bus.s_a));
        chk("dsp_b", 64'(dsp_b), 64'(bus.s_b));
      end
      opm_now = '0;
      if (bus.cmd_valid && bus.cmd_ready) begin
        cur_sub = bus.cmd_sub;
        elem = 0;
        if (bus.cmd_len == '0) begin
          last_ev = cyc;
          exp_lat = 1;
        end
      end
      if (acc) begin
        opm_now    = (elem == 0) ? 8'h01 : 8'h09;
        opm_now[7] = cur_sub;
        elem++;
        last_ev = cyc;
        exp_lat = 3;
      end
      acc_d2 = acc_d1;
      acc_d1 = acc;
      opm_d1 = opm_now;
      if (bus.r_valid && !prev_rv) chk("r_valid_latency", 64'(cyc - last_ev), 64'(exp_lat));
      prev_rv = bus.r_valid;
      if (bus.r_valid && bus.r_ready) begin
        if (sb_q.size() == 0) begin
          fail("unexpected_result");
        end else begin
          e = sb_q.pop_front();
          chk("r_data", 64'(bus.r_data), 64'(e.data));
          if (e.chk_carry) chk("r_carry", 64'(bus.r_carry), 64'd0);
        end
      end
    end
  end

  // ---------------- stimulus -------------------------------------------------
  task automatic wait_idle();
    int t = 0;
    while (!bus.cmd_ready && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.cmd_ready) fail("wait_idle_timeout");
  endtask

  // gap: 0 back-to-back, 1 bubble before every pair after the first, 2 random.
  task automatic send_cmd(input int len, input bit sub, input int gap,
                          input int stop_at, input bit wait_done);
    logic [W4-1:0] sum;
    exp_t          e;
    int            t;
    sum = '0;
    for (int i = 0; i < len; i++) sum += W4'(a_arr[i]) * W4'(b_arr[i]);
    e.data      = sub ? (W4'(0) - sum) : sum;
    e.chk_carry = !sub || (len == 0);
    wait_idle();
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LW'(len);
    bus.cmd_sub   = sub;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < stop_at; i++) begin
      if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 2) == 0)) begin
        bus.s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      bus.s_valid = 1'b1;
      bus.s_a     = a_arr[i];
      bus.s_b     = b_arr[i];
      t = 0;
      while (!bus.s_ready && t < 500) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (!bus.s_ready) begin
        fail("s_ready_timeout");
        bus.s_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b0;
    if (wait_done) wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    chk({tag, "_s_ready"}, 64'(bus.s_ready), 64'd0);
    chk({tag, "_r_valid"}, 64'(bus.r_valid), 64'd0);
    chk({tag, "_r_data"}, 64'(bus.r_data), 64'd0);
    chk({tag, "_r_carry"}, 64'(bus.r_carry), 64'd0);
    chk({tag, "_dsp_opmode"}, 64'(dsp_opmode), 64'd0);
    chk({tag, "_ces"}, 64'({dsp_cea, dsp_ceb, dsp_ceopmode, dsp_cem, dsp_cep, dsp_cecarryin}), 64'd0);
    chk({tag, "_dsp_ab"}, 64'({dsp_a, dsp_b}), 64'd0);
  endtask

  initial begin
    int t;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_sub   = 1'b0;
    bus.s_valid   = 1'b0;
    bus.s_a       = '0;
    bus.s_b       = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: LEN=4 back-to-back -> 70
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = W2'(i + 1);
      b_arr[i] = W2'(i + 5);
    end
    send_cmd(4, 1'b0, 0, 4, 1'b1);
    // 2: same with bubbles
    send_cmd(4, 1'b0, 1, 4, 1'b1);
    // 3: subtract, LEN=2 -> -26
    a_arr[0] = 18'd3; a_arr[1] = 18'd4;
    b_arr[0] = 18'd2; b_arr[1] = 18'd5;
    send_cmd(2, 1'b1, 0, 2, 1'b1);
    // 4: LEN=0 -> result next cycle, no stream
    send_cmd(0, 1'b0, 0, 0, 1'b0);
    chk("len0_r_valid", 64'(bus.r_valid), 64'd1);
    chk("len0_s_ready", 64'(bus.s_ready), 64'd0);
    wait_idle();

    // 5: result held with r_ready low, then two back-to-back commands
    hold_mode = 1'b1;
    a_arr[0] = 18'd2; b_arr[0] = 18'd3;
    send_cmd(1, 1'b0, 0, 1, 1'b0);
    t = 0;
    while (!bus.r_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.r_valid) fail("hold_r_valid_timeout");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold_r_data", 64'(bus.r_data), 64'd6);
      chk("hold_ready", 64'({bus.cmd_ready, bus.s_ready}), 64'd0);
    end
    hold_mode = 1'b0;
    wait_idle();
    a_arr[0] = 18'd4; b_arr[0] = 18'd5;
    send_cmd(1, 1'b0, 0, 1, 1'b1);

    // 6: reset after 2 of 4 pairs, then LEN=1 7*9 -> 63
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = W2'(10 + i);
      b_arr[i] = W2'(20 + i);
    end
    send_cmd(4, 1'b0, 0, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sb_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    a_arr[0] = 18'd7; b_arr[0] = 18'd9;
    send_cmd(1, 1'b0, 0, 1, 1'b1);

    // 7: randomized commands with random bubbles and back-pressure
    rand_rdy = 1'b1;
    for (int c = 0; c < 25; c++) begin
      int len;
      len = $urandom_range(0, 6);
      for (int i = 0; i < len; i++) begin
        a_arr[i] = W2'($urandom);
        b_arr[i] = W2'($urandom);
      end
      send_cmd(len, 1'($urandom_range(0, 1)), 2, len, 1'b0);
    end
    rand_rdy = 1'b0;
    t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
